// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all 2**N_IN input vectors, compares dut_out to expected, reports busy/done/pass/err_count/first_err/captured
module truth_table_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      vec,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err,
  output logic [2**N_IN-1:0]   captured
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, SAMPLE = 2'd2, DONE = 2'd3;
  localparam logic [1:0] FIRST = SETTLE == 0 ? SAMPLE : WAIT;
  localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN:0] MAX_ERR = {1'b1, {N_IN{1'b0}}};
  logic [1:0] state;
  logic [3:0] cnt;
  logic [2**N_IN-1:0] exp_q;
  logic miss;
  always_comb begin
    busy = state == WAIT || state == SAMPLE;
    miss = dut_out != exp_q[vec];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      exp_q     <= '0;
      vec       <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      first_err <= '0;
      captured  <= '0;
    end else begin
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          exp_q     <= expected;
          vec       <= '0;
          err_count <= '0;
          first_err <= '0;
          captured  <= '0;
          pass      <= 1'b0;
          cnt       <= '0;
          state     <= FIRST;
        end
        WAIT: begin
          if (abort) begin
            pass  <= 1'b0;
            state <= IDLE;
          end else if (cnt == WAIT_LAST) state <= SAMPLE;
          else cnt <= cnt + 1'b1;
        end
        SAMPLE: begin
          if (abort) begin
            pass  <= 1'b0;
            state <= IDLE;
          end else begin
            captured[vec] <= dut_out;
            if (miss && err_count != MAX_ERR) err_count <= err_count + 1'b1;
            if (miss && err_count == '0) first_err <= vec;
            cnt <= '0;
            if (&vec) state <= DONE;
            else begin
              vec   <= vec + 1'b1;
              state <= FIRST;
            end
          end
        end
        default: begin
          pass  <= err_count == '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed checks of truth_table_checker sweeps, latency, abort and reset
module tb_truth_table_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start1 = 1'b0, start2 = 1'b0, abort1 = 1'b0, abort2 = 1'b0, tie0 = 1'b0;
  logic [15:0] exp1 = '0;
  logic [7:0] exp2 = '0;
  logic [3:0] vec1, fe1;
  logic [2:0] vec2, fe2;
  logic [4:0] ec1;
  logic [3:0] ec2;
  logic [15:0] cap1;
  logic [7:0] cap2;
  logic busy1, done1, pass1, busy2, done2, pass2, dout1, dout2;
  int checks = 0, errors = 0, lat, n, done_seen;
  logic again;
  always #5 clk = ~clk;
  always_comb begin
    dout1 = tie0 ? 1'b0 : (~vec1[3] & ~vec1[1] & vec1[0]) | (vec1[3] & ~vec1[2]) | (~vec1[2] & vec1[0]);
    dout2 = (~vec2[2] & vec2[0]) | (vec2[2] & ~vec2[1]);
  end
  truth_table_checker #(.N_IN(4), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp1), .vec(vec1),
    .dut_out(dout1), .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .first_err(fe1), .captured(cap1));
  truth_table_checker #(.N_IN(3), .SETTLE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .expected(exp2), .vec(vec2),
    .dut_out(dout2), .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2),
    .first_err(fe2), .captured(cap2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int which, output int l);
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    l = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (which == 1 ? done1 : done2) begin
        l = k;
        break;
      end
    end
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vec", vec1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_err", ec1, 0);
    chk("rst_first", fe1, 0);
    chk("rst_cap", cap1, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    exp1 = 16'h0F2A;
    run(1, lat);
    chk("good_lat", lat, 33);
    chk("good_pass", pass1, 1);
    chk("good_err", ec1, 0);
    chk("good_cap", cap1, 16'h0F2A);
    chk("good_vec", vec1, 15);
    chk("good_busy", busy1, 0);
    @(posedge clk); #1;
    chk("done_pulse", done1, 0);
    exp1 = 16'h0F2B;
    run(1, lat);
    chk("one_lat", lat, 33);
    chk("one_pass", pass1, 0);
    chk("one_err", ec1, 1);
    chk("one_first", fe1, 0);
    chk("one_cap", cap1, 16'h0F2A);
    exp1 = 16'h0F2A;
    tie0 = 1'b1;
    run(1, lat);
    chk("tie_pass", pass1, 0);
    chk("tie_err", ec1, 7);
    chk("tie_first", fe1, 1);
    chk("tie_cap", cap1, 0);
    tie0 = 1'b0;
    exp1 = 16'hF0D5;
    run(1, lat);
    chk("all_err", ec1, 16);
    chk("all_first", fe1, 0);
    chk("all_pass", pass1, 0);
    exp2 = 8'h3A;
    run(2, lat);
    chk("n3_lat", lat, 9);
    chk("n3_pass", pass2, 1);
    chk("n3_cap", cap2, 8'h3A);
    chk("n3_err", ec2, 0);
    exp1 = 16'h0F2A;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("busy_after_start", busy1, 1);
    again = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (done1) begin
        lat = k;
        break;
      end
      if (vec1 == 4'd5 && !again) begin
        start1 = 1'b1;
        exp1 = 16'hFFFF;
        again = 1'b1;
      end
    end
    chk("restart_lat", lat, 33);
    chk("restart_pass", pass1, 1);
    chk("restart_err", ec1, 0);
    exp1 = 16'h0F2B;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (vec1 != 4'd9 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach", vec1, 9);
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    chk("abort_busy", busy1, 0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done1) done_seen++;
    end
    chk("abort_nodone", done_seen, 0);
    chk("abort_pass", pass1, 0);
    chk("abort_err", ec1, 1);
    chk("abort_first", fe1, 0);
    chk("abort_cap", cap1, 16'h012A);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (vec1 != 4'd7 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reach", vec1, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_vec", vec1, 0);
    chk("mid_busy", busy1, 0);
    chk("mid_done", done1, 0);
    chk("mid_pass", pass1, 0);
    chk("mid_err", ec1, 0);
    chk("mid_cap", cap1, 0);
    @(posedge clk); #1;
    chk("mid_hold_busy", busy1, 0);
    rst_n = 1'b1;
    exp1 = 16'h0F2A;
    run(1, lat);
    chk("post_lat", lat, 33);
    chk("post_pass", pass1, 1);
    chk("post_cap", cap1, 16'h0F2A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter N_IN, default 4: number of inputs of the function under test; legal range 1..6.
REQ-002 Parameter SETTLE, default 1: wait cycles between driving a vector and sampling the response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a full truth-table sweep; sampled in IDLE only.
REQ-006 abort  input  1  synchronous cancel of a running sweep.
REQ-007 expected  input  2**N_IN  expected truth table; bit i is the expected output for input vector i.
REQ-008 vec  output  N_IN  input vector driven to the function under test; MSB is the first input, e.g. {a,b,c,d}.
REQ-009 dut_out  input  1  response of the function under test.
REQ-010 busy  output  1  high from the cycle after start is accepted until the sweep ends.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 err_count  output  N_IN+1  number of mismatching vectors.
REQ-014 first_err  output  N_IN  lowest vector index that mismatched.
REQ-015 captured  output  2**N_IN  observed truth table; bit i is dut_out sampled for vector i.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, SAMPLE and DONE.
REQ-017 IDLE with start=1 SHALL:
- latch expected;
- set vec=0;
- clear err_count, first_err, captured and pass;
- enter WAIT, or SAMPLE when SETTLE=0.
REQ-018 WAIT SHALL last exactly SETTLE cycles with vec held stable, then enter SAMPLE.
REQ-019 SAMPLE SHALL last one cycle and perform all of:
- captured[vec] <= dut_out;
- on dut_out != latched expected[vec], increment err_count;
- on that mismatch, load first_err with vec when it is the first mismatch of the sweep.
REQ-020 After SAMPLE, when vec != 2**N_IN-1: vec SHALL increment and the FSM SHALL re-enter WAIT (or SAMPLE when SETTLE=0); otherwise it SHALL enter DONE.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE, and it SHALL set pass=1 exactly when err_count=0.
REQ-022 Latency: done SHALL be high in the cycle starting 2**N_IN*(SETTLE+1)+1 rising edges after the edge that accepted start.
REQ-023 vec SHALL not wrap during a sweep and SHALL hold 2**N_IN-1 in DONE and IDLE until the next start.
REQ-024 start while not in IDLE SHALL be ignored, and changes on expected during a sweep SHALL have no effect.
REQ-025 abort=1 in WAIT or SAMPLE SHALL:
- return the FSM to IDLE on the next edge;
- discard that cycle's sample;
- suppress done;
- force pass=0;
- leave err_count, first_err and captured with their partial values.
REQ-026 abort=1 in IDLE or DONE SHALL have no effect, so done still pulses.
REQ-027 err_count SHALL saturate at 2**N_IN, and first_err SHALL be 0 whenever err_count=0.
REQ-028 busy SHALL be 1 in WAIT and SAMPLE and 0 in IDLE and DONE.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, force all of:
- FSM to IDLE;
- vec=0, busy=0, done=0, pass=0;
- err_count=0, first_err=0, captured=0.
REQ-030 Reset asserted mid-sweep SHALL discard the sweep without a done pulse, and start SHALL be honoured from the first rising edge after rst_n returns high.

Verification
REQ-031 N_IN=4, SETTLE=1, DUT s=(~a&~c&d)|(a&~b)|(~b&d), expected=16'h0F2A, pulse start -> done exactly 33 edges later, pass=1, err_count=0, captured=16'h0F2A.
REQ-032 Same DUT, expected=16'h0F2B -> pass=0, err_count=1, first_err=0, captured=16'h0F2A.
REQ-033 dut_out tied 0, expected=16'h0F2A -> pass=0, err_count=7, first_err=1, captured=16'h0000.
REQ-034 N_IN=3, SETTLE=0, DUT s=(~a&d)|(a&~b) on {a,b,d}, expected=8'h3A -> done 9 edges after start, pass=1.
REQ-035 Abort and restart sequence:
- start, then start again at vector 5 -> second start ignored, done at 33 edges;
- new sweep, then abort at vector 9 -> busy=0 next cycle, no done, pass=0.
REQ-036 Reset mid-sweep: rst_n low at vector 7 -> all outputs 0 with no edge; start after release -> full correct sweep.
